// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST words into an async-FIFO write port, with one bubble cycle per grant.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e              state_q;
    logic [ID_W-1:0]     grant_id_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [BC_W-1:0]     beat_cnt_q;

    logic                g_valid;
    logic                g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                pick_valid;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     cand;
    logic                xfer;
    logic                burst_end;

    // Select the granted requester's valid/last/data.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id_q) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: first valid requester searching upward from rr_ptr+1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_valid && req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Transfer qualification and burst termination (last word, beat limit, withdrawal).
    always_comb begin
        xfer      = (state_q == BURST) && g_valid && !wfull;
        burst_end = (state_q == BURST) &&
                    (!g_valid ||
                     (xfer && (g_last || ((32'(beat_cnt_q) + 32'd1) == MAX_BURST))));
    end

    // Write-port outputs are combinational so a word moves in the cycle it is offered.
    always_comb begin
        winc      = xfer;
        wdata     = g_data;
        req_ready = '0;
        if ((state_q == BURST) && !wfull) begin
            req_ready = NUM_REQ'(1) << grant_id_q;
        end
        busy      = (state_q == BURST);
        grant_id  = grant_id_q;
    end

    // Arbiter FSM: grant in IDLE, count beats in BURST, hand the pointer over on exit.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id_q <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + BC_W'(1);
                    end
                    if (burst_end) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_id_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a transaction-level model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned MB = 4;
    localparam int unsigned IW = 2;

    logic              wclk = 1'b0;
    logic              wrst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              wfull;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [IW-1:0]     grant_id;
    logic              busy;

    int unsigned seq [N];
    int          errors = 0;
    int          checks = 0;

    // Model state: whether a burst is open, who owns it, pointer, beats so far.
    bit          m_busy;
    int          m_gid;
    int          m_rr;
    int          m_beats;

    int          wl_gid[$];
    int          wl_data[$];
    bit          busy_hist[$];

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    // Each requester's word encodes its index and a running sequence number.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'(i * 64 + seq[i] % 64);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_gid   = 0;
        m_rr    = N - 1;
        m_beats = 0;
    endtask

    // Reset pulse starting mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #1 wrst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_winc", int'(winc), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: inputs were applied at the negedge; check, advance model, wait.
    task automatic cycle(input bit rst_mid);
        int e_ready, e_winc, e_wdata;
        bit found;
        #1;
        e_ready = 0;
        e_winc  = 0;
        e_wdata = 0;
        if (m_busy) begin
            if (!wfull) e_ready = 1 << m_gid;
            e_winc  = (req_valid[m_gid] && !wfull) ? 1 : 0;
            e_wdata = m_gid * 64 + int'(seq[m_gid] % 64);
        end
        chk("busy", int'(busy), int'(m_busy));
        chk("grant_id", int'(grant_id), m_gid);
        chk("winc", int'(winc), e_winc);
        chk("req_ready", int'(req_ready), e_ready);
        if (e_winc != 0) chk("wdata", int'(wdata), e_wdata);
        busy_hist.push_back(busy);
        if (winc) begin
            wl_gid.push_back(int'(grant_id));
            wl_data.push_back(int'(wdata));
        end
        if (rst_mid) begin
            do_reset();
            return;
        end
        if (!m_busy) begin
            if (req_valid != '0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (!found && req_valid[c]) begin
                        found = 1'b1;
                        m_gid = c;
                    end
                end
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else if (!req_valid[m_gid]) begin
            m_busy = 1'b0;
            m_rr   = m_gid;
        end else if (!wfull) begin
            seq[m_gid]++;
            m_beats++;
            if (req_last[m_gid] || m_beats == MB) begin
                m_busy = 1'b0;
                m_rr   = m_gid;
            end
        end
        @(negedge wclk);
    endtask

    task automatic start();
        req_valid = '0;
        req_last  = '0;
        wfull     = 1'b0;
        do_reset();
        for (int i = 0; i < N; i++) seq[i] = 0;
        wl_gid.delete();
        wl_data.delete();
        busy_hist.delete();
    endtask

    initial begin
        int e032[12];
        int n0;
        bit done;
        e032 = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        wfull     = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        model_reset();
        @(negedge wclk);

        // Two requesters alternate in full bursts with a bubble between grants.
        start();
        req_valid = 4'b0101;
        repeat (15) cycle(1'b0);
        chk("s032_count", wl_gid.size(), 12);
        for (int k = 0; k < 12 && k < wl_gid.size(); k++) chk("s032_gid", wl_gid[k], e032[k]);

        // Short packet: last on the second word ends the burst.
        start();
        for (int c = 0; c < 6; c++) begin
            req_valid = (seq[1] < 2) ? 4'b0010 : 4'b0000;
            req_last  = (seq[1] == 1) ? 4'b0010 : 4'b0000;
            cycle(1'b0);
        end
        chk("s033_count", wl_gid.size(), 2);
        chk("s033_busy_b2", int'(busy_hist[2]), 1);
        chk("s033_busy_after", int'(busy_hist[3]), 0);
        req_last  = '0;
        req_valid = 4'b1111;
        cycle(1'b0);
        chk("s033_next_grant", int'(grant_id), 2);

        // FIFO full stalls the burst for five cycles after beat 1.
        start();
        req_valid = 4'b1000;
        cycle(1'b0);
        cycle(1'b0);
        wfull = 1'b1;
        repeat (5) cycle(1'b0);
        chk("s034_stalled", wl_gid.size(), 1);
        wfull = 1'b0;
        repeat (4) cycle(1'b0);
        chk("s034_total", wl_gid.size(), 4);
        chk("s034_idle_after", int'(busy_hist[busy_hist.size()-1]), 0);

        // Granted requester withdraws after two beats.
        start();
        req_valid = 4'b1111;
        repeat (3) cycle(1'b0);
        req_valid = 4'b1110;
        cycle(1'b0);
        cycle(1'b0);
        n0 = 0;
        foreach (wl_gid[k]) if (wl_gid[k] == 0) n0++;
        chk("s035_beats", n0, 2);
        chk("s035_next_grant", int'(grant_id), 1);

        // Reset during beat 3 of grant 2; requester 0 first afterwards.
        start();
        req_valid = 4'b0100;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            if (wl_gid.size() == 2) begin
                cycle(1'b1);
                done = 1'b1;
            end else begin
                cycle(1'b0);
            end
        end
        chk("s036_reset_hit", int'(done), 1);
        chk("s036_beats", wl_gid.size(), 3);
        req_valid = 4'b1111;
        cycle(1'b0);
        chk("s036_first_grant", int'(grant_id), 0);
        chk("s036_busy", int'(busy), 1);

        // All requesters valid: strict round robin, data in order per source.
        start();
        req_valid = 4'b1111;
        repeat (40) cycle(1'b0);
        chk("s037_count", wl_gid.size(), 32);
        for (int k = 0; k < 32 && k < wl_gid.size(); k++) begin
            int g;
            g = (k / 4) % 4;
            chk("s037_gid", wl_gid[k], g);
            chk("s037_data", wl_data[k], g * 64 + (k / 16) * 4 + k % 4);
        end

        // Randomized traffic with stalls, withdrawals and occasional resets.
        start();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(9) < 3) req_valid[i] = ($urandom_range(9) < 6);
                req_last[i] = ($urandom_range(3) == 0);
            end
            wfull = ($urandom_range(3) == 0);
            cycle($urandom_range(120) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of each requester data word and of wdata.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (legal range 2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum beats per grant (legal range 1..16).
REQ-004 SHALL have port wclk  input  1  meaning the FIFO write-domain clock; all state changes on its rising edge.
REQ-005 SHALL have port wrst_n  input  1  meaning the asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  meaning bit i is set when requester i has a word to write.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  meaning slice i carries requester i's word.
REQ-008 SHALL have port req_last  input  NUM_REQ  meaning bit i marks requester i's current word as end of its packet.
REQ-009 SHALL have port req_ready  output  NUM_REQ  meaning bit i is set when requester i's word is accepted this cycle.
REQ-010 SHALL have port wfull  input  1  meaning the FIFO write-side full flag.
REQ-011 SHALL have port winc  output  1  meaning the FIFO write-increment strobe.
REQ-012 SHALL have port wdata  output  DATA_WIDTH  meaning the FIFO write data.
REQ-013 SHALL have port grant_id  output  clog2(NUM_REQ)  meaning the index of the requester currently or last granted.
REQ-014 SHALL have port busy  output  1  meaning the arbiter is in state BURST.

Function
REQ-015 SHALL implement the FSM states IDLE and BURST, registered on wclk.
REQ-016 In IDLE with any req_valid set, the FSM SHALL select the first set bit searching upward from rr_ptr+1 (modulo NUM_REQ), load grant_id with that index, clear beat_cnt, and enter BURST on the next edge.
REQ-017 In IDLE with no req_valid set, the FSM SHALL remain in IDLE, and grant_id and rr_ptr SHALL hold.
REQ-018 In BURST, the arbiter SHALL compute xfer = req_valid[grant_id] && !wfull combinationally.
REQ-019 In BURST, req_ready[grant_id] SHALL equal !wfull, and every other req_ready bit SHALL be 0.
REQ-020 winc SHALL equal xfer, and wdata SHALL equal req_data slice grant_id, in the same cycle, with no added latency.
REQ-021 In IDLE, winc and all req_ready bits SHALL be 0 (one-cycle arbitration bubble per grant).
REQ-022 On each xfer, beat_cnt SHALL increment by 1; beat_cnt SHALL be clog2(MAX_BURST+1) bits wide and SHALL never exceed MAX_BURST.
REQ-023 BURST SHALL exit to IDLE on the edge after any of: (a) xfer with req_last[grant_id]=1; (b) xfer with beat_cnt+1 == MAX_BURST; (c) req_valid[grant_id]=0 (requester withdrew).
REQ-024 On exit from BURST, rr_ptr SHALL be loaded with grant_id.
REQ-025 While wfull=1 in BURST, the FSM SHALL stay in BURST, beat_cnt SHALL hold, winc SHALL be 0, and wdata SHALL be don't-care, provided req_valid[grant_id]=1.
REQ-026 If wfull=1 and req_valid[grant_id]=0 in the same cycle, rule (c) SHALL apply and the FSM SHALL exit.
REQ-027 Changes on non-granted req_valid bits during BURST SHALL have no effect until the next IDLE.
REQ-028 A requester holding req_valid=1 continuously SHALL be granted within NUM_REQ grants (starvation-free).

Reset
REQ-029 On wrst_n=0, asynchronously: state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1, beat_cnt=0, winc=0, req_ready=0, busy=0.
REQ-030 Reset asserted mid-BURST SHALL abort the burst immediately with no further winc, and requester 0 SHALL have first priority after release.
REQ-031 Deassertion of wrst_n SHALL be synchronous to wclk; outputs SHALL remain at reset values until the first edge after release.

Verification
REQ-032 Reset release, req_valid=4'b0101, wfull=0, no req_last -> grant 0 for 4 beats, 1 idle cycle, grant 2 for 4 beats, then grant 0 again.
REQ-033 Requester 1 only, req_last on its 2nd word -> exactly 2 winc pulses, busy=0 on the following cycle, rr_ptr=1.
REQ-034 Grant 3 active, wfull held high for 5 cycles after beat 1 -> winc=0 and req_ready=0 for those 5 cycles, then beats 2..4 complete, total 4 winc pulses.
REQ-035 Granted requester drops req_valid after beat 2 -> exit to IDLE after exactly 2 beats, next grant is the next valid index above it.
REQ-036 wrst_n pulsed low during beat 3 of grant 2 -> winc=0 immediately, post-reset first grant goes to requester 0 when req_valid=4'b1111.
REQ-037 All four requesters valid for 40 cycles, MAX_BURST=4 -> grant order 0,1,2,3,0,..., each wdata matches its source in order, and no word is duplicated or lost.
